// File: rtl/axis_if.sv
// AXI-Stream handshake bundle: data, valid, last and ready for one stream direction.
interface axis_if #(
   parameter int DW = 24
) ();
   logic [DW-1:0] tdata;
   logic          tvalid;
   logic          tlast;
   logic          tready;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_skid_fifo.sv
// AXI-Stream elastic buffer: output register backed by a small circular store,
// with occupancy/almost-full reporting and optional store-and-forward gating.
module axis_skid_fifo #(
   parameter int DW          = 24,
   parameter int DEPTH       = 4,
   parameter int AFULL       = 3,
   parameter int PACKET_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   axis_if.slave                      s_axis,
   axis_if.master                     m_axis,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       almost_full
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   // The store never holds more than DEPTH-1 words (one lives in the output
   // register); it is sized DEPTH so the pointers wrap naturally.
   logic [DW:0]    mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [DW-1:0]  out_data;
   logic           out_last;
   logic           out_valid;

   logic           push;
   logic           pop;
   logic           mem_empty;
   logic           out_load;
   logic           bypass;
   logic           mem_rd;
   logic           mem_wr;
   logic [CW-1:0]  count_next;

   assign s_axis.tready = !rst && (count != CW'(DEPTH));
   assign m_axis.tdata  = out_data;
   assign m_axis.tlast  = out_last;

   always_comb begin
      push       = s_axis.tvalid && s_axis.tready;
      pop        = m_axis.tvalid && m_axis.tready;
      mem_empty  = (count == CW'(out_valid));
      out_load   = !out_valid || pop;
      bypass     = out_load && mem_empty && push;
      mem_rd     = out_load && !mem_empty;
      mem_wr     = push && !bypass;
      count_next = count + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         almost_full <= 1'b0;
         out_valid   <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         count       <= count_next;
         almost_full <= (count_next >= CW'(AFULL));
         if (out_load)
            out_valid <= push || !mem_empty;
         if (mem_wr)
            wr_ptr <= wr_ptr + PW'(1);
         if (mem_rd)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr)
         mem[wr_ptr] <= {s_axis.tlast, s_axis.tdata};
      if (mem_rd)
         {out_last, out_data} <= mem[rd_ptr];
      else if (bypass)
         {out_last, out_data} <= {s_axis.tlast, s_axis.tdata};
   end

   generate
      if (PACKET_MODE != 0) begin : g_pkt
         logic [CW-1:0] pkts;
         logic          pkt_in;
         logic          pkt_out;

         assign pkt_in  = push && s_axis.tlast;
         assign pkt_out = pop && m_axis.tlast;

         always_ff @(posedge clk) begin
            if (rst)
               pkts <= '0;
            else
               pkts <= pkts + CW'(pkt_in) - CW'(pkt_out);
         end

         // Release when a whole packet is stored, or when full so that
         // packets longer than the buffer cannot deadlock.
         assign m_axis.tvalid = out_valid && ((pkts != '0) || (count == CW'(DEPTH)));
      end else begin : g_cut
         assign m_axis.tvalid = out_valid;
      end
   endgenerate
endmodule

// File: tb/tb_axis_skid_fifo.sv
// Bench for axis_skid_fifo: a cut-through and a packet-mode instance, each
// tracked by a scoreboard queue plus directed scenario checks.
module tb_axis_skid_fifo;
   localparam int DW    = 24;
   localparam int DEPTH = 4;
   localparam int AFULL = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
   } word_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   axis_if #(.DW(DW)) s0 ();
   axis_if #(.DW(DW)) m0 ();
   axis_if #(.DW(DW)) s1 ();
   axis_if #(.DW(DW)) m1 ();

   logic [CW-1:0] count0, count1;
   logic          af0, af1;

   axis_skid_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL), .PACKET_MODE(0)) dut0 (
      .clk(clk), .rst(rst), .s_axis(s0), .m_axis(m0), .count(count0), .almost_full(af0));

   axis_skid_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL), .PACKET_MODE(1)) dut1 (
      .clk(clk), .rst(rst), .s_axis(s1), .m_axis(m1), .count(count1), .almost_full(af1));

   int    tests = 0;
   int    fails = 0;
   int    rx0   = 0;
   int    rx1   = 0;
   bit    live  = 1'b0;
   word_t q0[$];
   word_t q1[$];
   word_t exp0, exp1, in0, in1;

   // Scoreboard for the cut-through instance; sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         q0.delete();
      end else if (live) begin
         tests++;
         if (count0 !== CW'(q0.size())) begin
            fails++; $display("FAIL sb0_count: got %0d want %0d", count0, q0.size());
         end
         tests++;
         if (af0 !== (q0.size() >= AFULL)) begin
            fails++; $display("FAIL sb0_afull: got %b want %b", af0, q0.size() >= AFULL);
         end
         tests++;
         if (s0.tready !== (q0.size() != DEPTH)) begin
            fails++; $display("FAIL sb0_sready: got %b want %b", s0.tready, q0.size() != DEPTH);
         end
         tests++;
         if (m0.tvalid !== (q0.size() != 0)) begin
            fails++; $display("FAIL sb0_mvalid: got %b want %b", m0.tvalid, q0.size() != 0);
         end
         if (m0.tvalid === 1'b1 && m0.tready === 1'b1) begin
            tests++;
            rx0++;
            if (q0.size() == 0) begin
               fails++; $display("FAIL sb0_underflow: got %h want nothing", m0.tdata);
            end else begin
               exp0 = q0.pop_front();
               if ({m0.tdata, m0.tlast} !== exp0) begin
                  fails++;
                  $display("FAIL sb0_data: got %h/%b want %h/%b", m0.tdata, m0.tlast, exp0.data, exp0.last);
               end
            end
         end
         if (s0.tvalid === 1'b1 && s0.tready === 1'b1) begin
            in0.data = s0.tdata;
            in0.last = s0.tlast;
            q0.push_back(in0);
         end
      end
   end

   // Scoreboard for the packet-mode instance.
   always @(negedge clk) begin
      if (rst) begin
         q1.delete();
      end else if (live) begin
         automatic int  np = 0;
         automatic logic ev;
         foreach (q1[i]) if (q1[i].last) np++;
         ev = (q1.size() != 0) && (np != 0 || q1.size() == DEPTH);
         tests++;
         if (count1 !== CW'(q1.size())) begin
            fails++; $display("FAIL sb1_count: got %0d want %0d", count1, q1.size());
         end
         tests++;
         if (af1 !== (q1.size() >= AFULL)) begin
            fails++; $display("FAIL sb1_afull: got %b want %b", af1, q1.size() >= AFULL);
         end
         tests++;
         if (s1.tready !== (q1.size() != DEPTH)) begin
            fails++; $display("FAIL sb1_sready: got %b want %b", s1.tready, q1.size() != DEPTH);
         end
         tests++;
         if (m1.tvalid !== ev) begin
            fails++; $display("FAIL sb1_mvalid: got %b want %b", m1.tvalid, ev);
         end
         if (m1.tvalid === 1'b1 && m1.tready === 1'b1) begin
            tests++;
            rx1++;
            if (q1.size() == 0) begin
               fails++; $display("FAIL sb1_underflow: got %h want nothing", m1.tdata);
            end else begin
               exp1 = q1.pop_front();
               if ({m1.tdata, m1.tlast} !== exp1) begin
                  fails++;
                  $display("FAIL sb1_data: got %h/%b want %h/%b", m1.tdata, m1.tlast, exp1.data, exp1.last);
               end
            end
         end
         if (s1.tvalid === 1'b1 && s1.tready === 1'b1) begin
            in1.data = s1.tdata;
            in1.last = s1.tlast;
            q1.push_back(in1);
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic send0(input logic [DW-1:0] d, input logic l);
      logic acc;
      s0.tdata = d; s0.tlast = l; s0.tvalid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk); acc = s0.tready;
         @(posedge clk); #1;
         if (acc) begin
            s0.tvalid = 1'b0;
            return;
         end
      end
      s0.tvalid = 1'b0;
      tests++; fails++;
      $display("FAIL send0_timeout: got no ready want ready within 200 cycles");
   endtask

   task automatic send1(input logic [DW-1:0] d, input logic l);
      logic acc;
      s1.tdata = d; s1.tlast = l; s1.tvalid = 1'b1;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk); acc = s1.tready;
         @(posedge clk); #1;
         if (acc) begin
            s1.tvalid = 1'b0;
            return;
         end
      end
      s1.tvalid = 1'b0;
      tests++; fails++;
      $display("FAIL send1_timeout: got no ready want ready within 200 cycles");
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      tests++;
      if (count0 !== '0 || af0 !== 1'b0 || m0.tvalid !== 1'b0) begin
         fails++; $display("FAIL reset_state0: got %0d/%b/%b want 0/0/0", count0, af0, m0.tvalid);
      end
      tests++;
      if (count1 !== '0 || af1 !== 1'b0 || m1.tvalid !== 1'b0) begin
         fails++; $display("FAIL reset_state1: got %0d/%b/%b want 0/0/0", count1, af1, m1.tvalid);
      end
      tests++;
      if (s0.tready !== 1'b0) begin
         fails++; $display("FAIL reset_sready_low: got %b want 0", s0.tready);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (s0.tready !== 1'b1) begin
         fails++; $display("FAIL reset_sready_high: got %b want 1", s0.tready);
      end
      live = 1'b1;
      tick();
   endtask

   task automatic test_single();
      m0.tready = 1'b1;
      s0.tdata = 24'hABCDEF; s0.tlast = 1'b1; s0.tvalid = 1'b1;
      tests++;
      if (m0.tvalid !== 1'b0) begin
         fails++; $display("FAIL single_pre: got %b want 0", m0.tvalid);
      end
      tick();
      s0.tvalid = 1'b0;
      tests++;
      if (m0.tvalid !== 1'b1 || m0.tdata !== 24'hABCDEF || count0 !== CW'(1)) begin
         fails++; $display("FAIL single_out: got %b/%h/%0d want 1/abcdef/1", m0.tvalid, m0.tdata, count0);
      end
      tick();
      tests++;
      if (m0.tvalid !== 1'b0 || count0 !== '0) begin
         fails++; $display("FAIL single_drain: got %b/%0d want 0/0", m0.tvalid, count0);
      end
   endtask

   task automatic test_fill();
      logic [DW-1:0] want [5];
      logic [CW-1:0] wcnt [5];
      want = '{DW'(2), DW'(3), DW'(4), DW'(5), DW'(0)};
      wcnt = '{CW'(3), CW'(3), CW'(2), CW'(1), CW'(0)};
      m0.tready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         s0.tdata = DW'(i); s0.tlast = 1'b0; s0.tvalid = 1'b1;
         tick();
      end
      s0.tdata = DW'(5); s0.tlast = 1'b1;
      tests++;
      if (count0 !== CW'(4) || af0 !== 1'b1 || s0.tready !== 1'b0 || m0.tdata !== DW'(1)) begin
         fails++;
         $display("FAIL fill_full: got %0d/%b/%b/%h want 4/1/0/1", count0, af0, s0.tready, m0.tdata);
      end
      tick();
      tests++;
      if (count0 !== CW'(4) || m0.tdata !== DW'(1)) begin
         fails++; $display("FAIL fill_hold: got %0d/%h want 4/1", count0, m0.tdata);
      end
      m0.tready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i == 1) s0.tvalid = 1'b0;
         tests++;
         if (count0 !== wcnt[i] || (i < 4 && m0.tdata !== want[i])) begin
            fails++;
            $display("FAIL fill_drain%0d: got %0d/%h want %0d/%h", i, count0, m0.tdata, wcnt[i], want[i]);
         end
      end
      tests++;
      if (af0 !== 1'b0 || m0.tvalid !== 1'b0) begin
         fails++; $display("FAIL fill_empty: got %b/%b want 0/0", af0, m0.tvalid);
      end
   endtask

   task automatic test_random();
      int base;
      base = rx0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               while ($urandom_range(0, 3) == 0) tick();
               send0(DW'($urandom), $urandom_range(0, 7) == 0);
            end
         end
         begin
            for (int cyc = 0; cyc < 20000 && rx0 - base < 1000; cyc++) begin
               m0.tready = $urandom_range(0, 1) != 0;
               tick();
            end
         end
      join
      m0.tready = 1'b1;
      tests++;
      if (rx0 - base !== 1000 || q0.size() !== 0) begin
         fails++; $display("FAIL random_total: got %0d left %0d want 1000 left 0", rx0 - base, q0.size());
      end
   endtask

   task automatic test_packet_short();
      m1.tready = 1'b1;
      send1(DW'(24'h0000A1), 1'b0);
      tests++;
      if (m1.tvalid !== 1'b0 || count1 !== CW'(1)) begin
         fails++; $display("FAIL pkt3_w1: got %b/%0d want 0/1", m1.tvalid, count1);
      end
      tick();
      send1(DW'(24'h0000B2), 1'b0);
      tests++;
      if (m1.tvalid !== 1'b0 || count1 !== CW'(2)) begin
         fails++; $display("FAIL pkt3_w2: got %b/%0d want 0/2", m1.tvalid, count1);
      end
      tick();
      send1(DW'(24'h0000C3), 1'b1);
      tests++;
      if (m1.tvalid !== 1'b1 || m1.tdata !== 24'h0000A1 || count1 !== CW'(3)) begin
         fails++; $display("FAIL pkt3_release: got %b/%h/%0d want 1/0000a1/3", m1.tvalid, m1.tdata, count1);
      end
      tick();
      tests++;
      if (m1.tdata !== 24'h0000B2 || m1.tlast !== 1'b0) begin
         fails++; $display("FAIL pkt3_second: got %h/%b want 0000b2/0", m1.tdata, m1.tlast);
      end
      tick();
      tests++;
      if (m1.tdata !== 24'h0000C3 || m1.tlast !== 1'b1) begin
         fails++; $display("FAIL pkt3_last: got %h/%b want 0000c3/1", m1.tdata, m1.tlast);
      end
      tick();
      tests++;
      if (m1.tvalid !== 1'b0 || count1 !== '0) begin
         fails++; $display("FAIL pkt3_empty: got %b/%0d want 0/0", m1.tvalid, count1);
      end
   endtask

   task automatic test_packet_long();
      int base;
      base = rx1;
      m1.tready = 1'b1;
      for (int i = 0; i < 4; i++) send1(DW'(24'h000100 + i), 1'b0);
      tests++;
      if (count1 !== CW'(4) || m1.tvalid !== 1'b1 || m1.tdata !== 24'h000100) begin
         fails++; $display("FAIL pkt6_override: got %0d/%b/%h want 4/1/000100", count1, m1.tvalid, m1.tdata);
      end
      send1(DW'(24'h000104), 1'b0);
      send1(DW'(24'h000105), 1'b1);
      for (int cyc = 0; cyc < 50 && rx1 - base < 6; cyc++) tick();
      tests++;
      if (rx1 - base !== 6 || count1 !== '0) begin
         fails++; $display("FAIL pkt6_total: got %0d/%0d want 6/0", rx1 - base, count1);
      end
   endtask

   task automatic test_reset_mid();
      m0.tready = 1'b0;
      send0(DW'(24'h000011), 1'b0);
      send0(DW'(24'h000022), 1'b0);
      send0(DW'(24'h000033), 1'b0);
      tests++;
      if (count0 !== CW'(3)) begin
         fails++; $display("FAIL rstmid_held: got %0d want 3", count0);
      end
      rst = 1'b1;
      #1;
      tests++;
      if (s0.tready !== 1'b0) begin
         fails++; $display("FAIL rstmid_sready_low: got %b want 0", s0.tready);
      end
      tick();
      rst = 1'b0;
      #1;
      tests++;
      if (m0.tvalid !== 1'b0 || count0 !== '0 || s0.tready !== 1'b1 || af0 !== 1'b0) begin
         fails++;
         $display("FAIL rstmid_cleared: got %b/%0d/%b/%b want 0/0/1/0", m0.tvalid, count0, s0.tready, af0);
      end
      m0.tready = 1'b1;
      s0.tdata = 24'h000042; s0.tlast = 1'b0; s0.tvalid = 1'b1;
      tick();
      s0.tvalid = 1'b0;
      tests++;
      if (m0.tvalid !== 1'b1 || m0.tdata !== 24'h000042) begin
         fails++; $display("FAIL rstmid_after: got %b/%h want 1/000042", m0.tvalid, m0.tdata);
      end
      tick();
      tests++;
      if (count0 !== '0) begin
         fails++; $display("FAIL rstmid_drain: got %0d want 0", count0);
      end
   endtask

   initial begin
      rst = 1'b1;
      s0.tvalid = 1'b0; s0.tdata = '0; s0.tlast = 1'b0; m0.tready = 1'b1;
      s1.tvalid = 1'b0; s1.tdata = '0; s1.tlast = 1'b0; m1.tready = 1'b1;
      test_reset();
      test_single();
      test_fill();
      test_random();
      test_packet_short();
      test_packet_long();
      test_reset_mid();
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/axis_skid_fifo.md
Name: axis_skid_fifo

Overview:
AXI-Stream elastic buffer generalising the single-entry skid stage to a parametrised depth, with tlast pass-through, occupancy reporting and an optional packet (store-and-forward) mode. All outputs are registered or decoded from registers only. No combinational path exists from m_axis_tready to s_axis_tready. Sits between stream producers and consumers in DSP chains to break timing paths and absorb bursts.

Parameters:
DW, 24, data width in bits (>=1)
DEPTH, 4, total storage entries including output register; power of 2, 2..256
AFULL, 3, almost_full asserts when count >= AFULL (1..DEPTH)
PACKET_MODE, 0, 0 = cut-through; 1 = hold output until a complete packet is stored or buffer is full

Ports:
clk  in  1  clock
rst  in  1  reset
s_axis_tdata  in  DW  input data
s_axis_tvalid  in  1  input valid
s_axis_tlast  in  1  input end-of-packet
s_axis_tready  out  1  input ready
m_axis_tdata  out  DW  output data
m_axis_tvalid  out  1  output valid
m_axis_tlast  out  1  output end-of-packet
m_axis_tready  in  1  output ready
count  out  $clog2(DEPTH+1)  entries currently held, including output register
almost_full  out  1  registered, count >= AFULL

Behaviour:
- Reset rst is synchronous and active-high. Clock is clk; all state updates on its rising edge.
- Reset clears count, almost_full, the output-register valid flag, read/write pointers and the packet counter. m_axis_tvalid = 0. tdata/tlast storage is not reset.
- s_axis_tready = !rst && (count != DEPTH). It decodes from registered state only.
- push = s_axis_tvalid && s_axis_tready. pop = m_axis_tvalid && m_axis_tready.
- Each cycle: count_next = count + push - pop. Simultaneous push and pop leaves count unchanged. Count never exceeds DEPTH and never underflows.
- Latency: a word pushed into an empty buffer at edge N appears on m_axis_tdata/tvalid after edge N (1 cycle).
- Order is strict FIFO. A tlast bit always travels with its word.
- Throughput is 1 word/cycle sustained whenever 0 < count < DEPTH with both sides active.
- At full: s_axis_tready = 0. A pop at edge N raises tready after N. From then on, continuous push+pop holds count at DEPTH-1 at full rate.
- Output register refill: after a pop, or whenever the output is empty, the next stored word loads into the output register on the same edge. This includes bypass of a word pushed into an empty buffer.
- m_axis_tdata/tlast hold stable while m_axis_tvalid && !m_axis_tready (AXIS rule).
- PACKET_MODE=1:
  - pkts counts stored words with tlast=1, incremented on push of tlast and decremented on pop of tlast. Simultaneous increment and decrement leaves it unchanged.
  - m_axis_tvalid = out_valid && (pkts != 0 || count == DEPTH). The full override prevents deadlock on packets longer than DEPTH.
  - Once a pop of a non-tlast word has occurred in a packet, tvalid stays gated by the same rule; no extra holding is applied.
- PACKET_MODE=0: m_axis_tvalid = out_valid.
- almost_full is registered from count_next.
- Reset mid-packet or mid-burst discards all contents. tready = 0 during the rst cycle and returns to 1 on the next cycle.
- Valid is never dropped once asserted, except by pop or rst.

Test Plan:
1. DEPTH=4, single push 0xABCDEF at cycle 10, m_tready=1 -> m_tvalid high cycle 11 with 0xABCDEF; count 1 then 0.
2. m_tready=0, push 0x1..0x5 back-to-back -> 4 accepted; s_tready low after 4th; count=4, almost_full=1; release tready -> output 1,2,3,4 consecutive, then 5 accepted and output.
3. Both sides continuous random data, 1000 words, tready toggling 50% -> output sequence equals input sequence; no duplicates or drops; count never >4.
4. PACKET_MODE=1, push 3-word packet (tlast on 3rd) with 1-cycle gaps -> m_tvalid stays 0 until 3rd word stored, then 3 words stream out with tlast on last.
5. PACKET_MODE=1, 6-word packet, DEPTH=4 -> m_tvalid asserts when count=4 (full override); all 6 words delivered in order, tlast on 6th.
6. Buffer holding 3 words, assert rst one cycle -> next cycle m_tvalid=0, count=0, s_tready=1; subsequent push 0x42 emerges 1 cycle later.
